// File: rtl/memory_hs_pkg.sv
// memory_hs_pkg: shared state type and byte-lane helpers for memory_hs.
// Parity helpers are only used when MEMORY_HS_PARITY_EN is defined.
package memory_hs_pkg;

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int BYTES = DEF_DATA_WIDTH / 8;

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       en
    );
        return en ? new_b : old_b;
    endfunction

    // Even parity: stored bit makes the total count of ones even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/memory_hs_rd_pipe.sv
// memory_hs_rd_pipe: valid/data shift pipeline behind the registered RAM read.
// Each stage loads only when its input is valid, so the tail holds its last word.
module memory_hs_rd_pipe #(
    parameter int STAGES = 0,
    parameter int W      = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    if (STAGES == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok = ^{clk, reset};
        assign out_valid = in_valid;
        assign out_data  = in_data;
    end else begin : g_shift
        logic [STAGES-1:0] v;
        logic [W-1:0]      d [STAGES];

        always_ff @(posedge clk) begin
            if (!reset) begin
                v <= '0;
                for (int i = 0; i < STAGES; i++) d[i] <= '0;
            end else begin
                v[0] <= in_valid;
                if (in_valid) d[0] <= in_data;
                for (int i = 1; i < STAGES; i++) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) d[i] <= d[i-1];
                end
            end
        end

        assign out_valid = v[STAGES-1];
        assign out_data  = d[STAGES-1];
    end

endmodule

// File: rtl/memory_hs.sv
// memory_hs: single-port valid/ready memory with byte enables and a clear sweep.
// Optional per-byte even parity with error injection under MEMORY_HS_PARITY_EN.
module memory_hs
    import memory_hs_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_wr,
    input  logic                    req_rd,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
`ifdef MEMORY_HS_PARITY_EN
    input  logic                    parity_inj,
    output logic                    rsp_err,
`endif
    output logic                    busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 8;
`ifdef MEMORY_HS_PARITY_EN
    localparam int PW = DATA_WIDTH + 1;
`else
    localparam int PW = DATA_WIDTH;
`endif

    state_e                  state;
    state_e                  state_nx;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    wr_en;
    logic                    rd_en;
    logic                    rd_v;
    logic [PW-1:0]           rd_next;
    logic [PW-1:0]           rd_word;
    logic [PW-1:0]           pipe_out;

    always_ff @(posedge clk) begin
        if (!reset) state <= CLEAR;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            CLEAR: if (cnt == '1) state_nx = READY;
            READY: state_nx = READY;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        unique case (state)
            CLEAR: begin
                req_ready = 1'b0;
                busy      = 1'b1;
            end
            READY: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset)              cnt <= '0;
        else if (state == CLEAR) cnt <= cnt + 1'b1;
    end

    assign wr_en = req_valid && req_ready && req_wr;
    assign rd_en = req_valid && req_ready && req_rd;

    // Reset itself never writes; the sweep starts on the first cycle after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == CLEAR) begin
                mem[cnt] <= INIT_VALUE;
            end else if (wr_en) begin
                for (int i = 0; i < LANES; i++) begin
                    mem[req_addr][8*i +: 8] <= byte_merge(
                        mem[req_addr][8*i +: 8],
                        req_wdata[8*i +: 8],
                        req_be[i]);
                end
            end
        end
    end

`ifdef MEMORY_HS_PARITY_EN
    logic [LANES-1:0] par [DEPTH];
    logic [LANES-1:0] init_par;
    logic [LANES-1:0] wr_par;
    logic [LANES-1:0] rd_par;
    logic             par_err;

    always_comb begin
        init_par = '0;
        wr_par   = '0;
        rd_par   = '0;
        for (int i = 0; i < LANES; i++) begin
            init_par[i] = byte_parity(INIT_VALUE[8*i +: 8]);
            wr_par[i]   = byte_parity(req_wdata[8*i +: 8]) ^ parity_inj;
            rd_par[i]   = byte_parity(mem[req_addr][8*i +: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == CLEAR) begin
                par[cnt] <= init_par;
            end else if (wr_en) begin
                for (int i = 0; i < LANES; i++) begin
                    if (req_be[i]) par[req_addr][i] <= wr_par[i];
                end
            end
        end
    end

    assign par_err   = |(rd_par ^ par[req_addr]);
    assign rd_next   = {par_err, mem[req_addr]};
    assign rsp_rdata = pipe_out[DATA_WIDTH-1:0];
    assign rsp_err   = pipe_out[DATA_WIDTH];
`else
    assign rd_next   = mem[req_addr];
    assign rsp_rdata = pipe_out;
`endif

    // Registered RAM read captures the pre-write word on a combined rd/wr.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_v    <= 1'b0;
            rd_word <= '0;
        end else begin
            rd_v <= rd_en;
            if (rd_en) rd_word <= rd_next;
        end
    end

    memory_hs_rd_pipe #(
        .STAGES (RD_LATENCY - 1),
        .W      (PW)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_v),
        .in_data   (rd_word),
        .out_valid (rsp_valid),
        .out_data  (pipe_out)
    );

endmodule

// File: tb/tb_memory_hs.sv
// tb_memory_hs: two memory_hs instances (read latency 1 and 4) on shared stimulus,
// checked every cycle against an array/queue model of the memory.
`timescale 1ns/1ps
module tb_memory_hs;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] INIT = '1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_wr = 1'b0;
    logic          req_rd = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [NB-1:0] req_be = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          parity_inj = 1'b0;

    logic          rdy1, rdy4, busy1, busy4, v1, v4;
    logic [DW-1:0] d1, d4;
`ifdef MEMORY_HS_PARITY_EN
    logic          e1, e4;
`endif

    always #5 clk = ~clk;

    memory_hs #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .INIT_VALUE(INIT)
    ) u_l1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1),
        .req_addr(req_addr), .req_wr(req_wr), .req_rd(req_rd),
        .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(v1), .rsp_rdata(d1),
`ifdef MEMORY_HS_PARITY_EN
        .parity_inj(parity_inj), .rsp_err(e1),
`endif
        .busy(busy1)
    );

    memory_hs #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(4), .INIT_VALUE(INIT)
    ) u_l4 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy4),
        .req_addr(req_addr), .req_wr(req_wr), .req_rd(req_rd),
        .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(v4), .rsp_rdata(d4),
`ifdef MEMORY_HS_PARITY_EN
        .parity_inj(parity_inj), .rsp_err(e4),
`endif
        .busy(busy4)
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain memory array plus per-latency response queues.
    typedef struct {
        int          due;
        logic [DW-1:0] data;
        logic        err;
    } rsp_t;

    rsp_t          q1[$];
    rsp_t          q4[$];
    rsp_t          r_new;
    rsp_t          last_pushed;
    logic [DW-1:0] mmem [DEPTH];
    logic [NB-1:0] mbad [DEPTH];
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last4 = '0;
    int            edge_n = 0;
    int            since_rst = 0;
    bit            mready = 1'b0;
    bit            started = 1'b0;

    always @(posedge clk) begin
        edge_n++;
        if (!reset) begin
            started   = 1'b1;
            since_rst = 0;
            mready    = 1'b0;
            q1.delete();
            q4.delete();
            last1 = '0;
            last4 = '0;
        end else if (started) begin
            if (mready && req_valid) begin
                if (req_rd) begin
                    r_new.data = mmem[req_addr];
                    r_new.err  = |mbad[req_addr];
                    r_new.due  = edge_n;
                    q1.push_back(r_new);
                    r_new.due  = edge_n + 3;
                    q4.push_back(r_new);
                    last_pushed = r_new;
                end
                if (req_wr) begin
                    for (int i = 0; i < NB; i++) begin
                        if (req_be[i]) begin
                            mmem[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
                            mbad[req_addr][i] = parity_inj;
                        end
                    end
                end
            end
            since_rst++;
            if (since_rst == DEPTH) begin
                for (int a = 0; a < DEPTH; a++) begin
                    mmem[a] = INIT;
                    mbad[a] = '0;
                end
                mready = 1'b1;
            end
        end
    end

    bit exp_v;

    always @(negedge clk) begin
        if (started) begin
            chk("req_ready_l1", rdy1, mready);
            chk("req_ready_l4", rdy4, mready);
            chk("busy_l1", busy1, !mready);
            chk("busy_l4", busy4, !mready);

            if (q1.size() > 0 && q1[0].due < edge_n) void'(q1.pop_front());
            exp_v = q1.size() > 0 && q1[0].due == edge_n;
            chk("rsp_valid_l1", v1, exp_v);
            if (exp_v) begin
                chk("rsp_rdata_l1", d1, q1[0].data);
`ifdef MEMORY_HS_PARITY_EN
                chk("rsp_err_l1", e1, q1[0].err);
`endif
                last1 = q1[0].data;
                void'(q1.pop_front());
            end else begin
                chk("rsp_hold_l1", d1, last1);
            end

            if (q4.size() > 0 && q4[0].due < edge_n) void'(q4.pop_front());
            exp_v = q4.size() > 0 && q4[0].due == edge_n;
            chk("rsp_valid_l4", v4, exp_v);
            if (exp_v) begin
                chk("rsp_rdata_l4", d4, q4[0].data);
`ifdef MEMORY_HS_PARITY_EN
                chk("rsp_err_l4", e4, q4[0].err);
`endif
                last4 = q4[0].data;
                void'(q4.pop_front());
            end else begin
                chk("rsp_hold_l4", d4, last4);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [NB-1:0] be,
                        input logic inj);
        req_valid  = 1'b1;
        req_rd     = rd;
        req_wr     = wr;
        req_addr   = a;
        req_wdata  = d;
        req_be     = be;
        parity_inj = inj;
        cycle();
        req_valid  = 1'b0;
        req_rd     = 1'b0;
        req_wr     = 1'b0;
        parity_inj = 1'b0;
    endtask

    task automatic wait_sweep(input string name);
        int n;
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (busy1) n++;
            else break;
        end
        chk(name, n, DEPTH);
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        repeat (3) cycle();
        reset = 1'b1;
        // Requests during the sweep must be ignored.
        for (int k = 0; k < 40; k++) begin
            req_valid = k[0];
            req_rd    = 1'b1;
            req_addr  = AW'(k);
            cycle();
        end
        req_valid = 1'b0;
        req_rd    = 1'b0;
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        wait_sweep("sweep_cycles_after_restart");

        send(1, 0, 8'h00, '0, '0, 0);
        chk("pin_init_addr0", last_pushed.data, 32'hFFFF_FFFF);
        send(1, 0, 8'hFF, '0, '0, 0);
        chk("pin_init_addr_max", last_pushed.data, 32'hFFFF_FFFF);

        send(0, 1, 8'h10, 32'hAABB_CCDD, 4'b0101, 0);
        send(1, 0, 8'h10, '0, '0, 0);
        chk("pin_byte_enable", last_pushed.data, 32'hFFBB_FFDD);

        send(0, 1, 8'h05, 32'h1234_5678, 4'hF, 0);
        send(1, 0, 8'h05, '0, '0, 0);
        chk("pin_write_then_read", last_pushed.data, 32'h1234_5678);
        send(1, 1, 8'h05, 32'h0, 4'hF, 0);
        chk("pin_read_before_write", last_pushed.data, 32'h1234_5678);
        send(1, 0, 8'h05, '0, '0, 0);
        chk("pin_after_rw", last_pushed.data, 32'h0);
        send(0, 1, 8'h06, 32'hDEAD_BEEF, 4'h0, 0);
        send(1, 0, 8'h06, '0, '0, 0);
        chk("pin_be_zero_noop", last_pushed.data, 32'hFFFF_FFFF);
        send(0, 0, 8'h06, 32'h0, 4'hF, 0);
        repeat (5) cycle();

        for (int i = 0; i < 8; i++)
            send(0, 1, AW'(i), 32'h1000_0000 + 32'h0101_0101 * i, 4'hF, 0);
        for (int i = 0; i < 8; i++)
            send(1, 0, AW'(i), '0, '0, 0);
        chk("pin_stream_last", last_pushed.data, 32'h1707_0707);
        repeat (6) cycle();

`ifdef MEMORY_HS_PARITY_EN
        send(0, 1, 8'h03, 32'h0000_0055, 4'h1, 1);
        send(1, 0, 8'h03, '0, '0, 0);
        chk("pin_parity_injected", last_pushed.err, 1'b1);
        send(0, 1, 8'h03, 32'h0000_0055, 4'h1, 0);
        send(1, 0, 8'h03, '0, '0, 0);
        chk("pin_parity_clean", last_pushed.err, 1'b0);
        repeat (6) cycle();
`endif

        for (int k = 0; k < 300; k++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_rd     = $urandom_range(0, 1);
            req_wr     = $urandom_range(0, 1);
            req_addr   = AW'($urandom_range(0, 15));
            req_be     = NB'($urandom);
            req_wdata  = $urandom;
`ifdef MEMORY_HS_PARITY_EN
            parity_inj = ($urandom_range(0, 3) == 0);
`endif
            cycle();
        end
        req_valid  = 1'b0;
        req_rd     = 1'b0;
        req_wr     = 1'b0;
        parity_inj = 1'b0;
        repeat (6) cycle();

        // Reset in the middle of a read stream drops everything in flight.
        for (int i = 0; i < 3; i++)
            send(1, 0, AW'(i), '0, '0, 0);
        req_valid = 1'b1;
        req_rd    = 1'b1;
        req_addr  = 8'h03;
        reset     = 1'b0;
        cycle();
        chk("busy_after_midstream_reset", busy1, 1'b1);
        chk("rsp_valid_l4_after_reset", v4, 1'b0);
        req_valid = 1'b0;
        req_rd    = 1'b0;
        cycle();
        reset = 1'b1;
        repeat (8) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/memory_hs.md
Name: memory_hs

Overview:
- Next-generation single-port memory model for the mem testbench.
- Adds a valid/ready request channel, per-byte write enables and a parametrised read latency.
- Adds a hardware clear sweep after reset, so a fill loop is no longer needed.
- Sits between the bus driver and the scoreboard as the DUT memory.

Parameters:
- ADDR_WIDTH, 16, word address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- RD_LATENCY, 1, cycles from accepted read to rsp_valid; legal 1..4.
- INIT_VALUE, '1, word written to every location during the clear sweep.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted.
- req_addr  in  ADDR_WIDTH  word address.
- req_wr  in  1  write request.
- req_rd  in  1  read request.
- req_be  in  DATA_WIDTH/8  byte write enables.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read data valid; single-cycle pulse, no backpressure.
- rsp_rdata  out  DATA_WIDTH  read data.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state<=CLEAR, clear counter<=0.
  - Read pipeline flushed.
  - Outputs: rsp_valid=0, rsp_rdata=0, req_ready=0, busy=1.
  - Memory contents are not touched by reset itself.
- FSM states CLEAR and READY.
- CLEAR:
  - Writes INIT_VALUE to mem[cnt] each cycle; cnt increments.
  - req_ready=0, busy=1.
  - After writing address 2**ADDR_WIDTH-1 (cnt wraps to 0), go to READY next cycle.
  - Sweep takes exactly 2**ADDR_WIDTH cycles.
- READY:
  - req_ready=1, busy=0.
  - Request accepted on a cycle where req_valid && req_ready.
  - READY never returns to CLEAR except via reset.
- Write (accepted, req_wr=1):
  - For each byte i with req_be[i]=1: mem[addr][8i+7:8i] <= req_wdata byte i.
  - Bytes with req_be[i]=0 are unchanged.
  - req_be all-zero is a legal no-op write.
- Read (accepted, req_rd=1):
  - rsp_valid=1 exactly RD_LATENCY cycles after the accept edge, with rsp_rdata=mem[addr] as sampled at the accept edge.
  - The RAM read is registered; RD_LATENCY-1 further pipeline stages follow.
- Read and write in the same request: read-before-write; the read returns the old word, and the write takes effect.
- Back-to-back reads every cycle are supported: one response per cycle, in order.
- A write followed next cycle by a read to the same address returns the new data.
- Accepted request with req_rd=0 and req_wr=0: ignored.
- rsp_rdata holds its last value when rsp_valid=0.
- Reset asserted mid-pipeline: pending responses are dropped; no rsp_valid after reset.
- Reset during CLEAR: the sweep restarts from address 0.
- req_valid while req_ready=0: not accepted; the driver must hold the request.
- Address arithmetic is unsigned ADDR_WIDTH; no out-of-range addresses exist.

Optional Feature:
- Macro MEMORY_HS_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte alongside the data; the clear sweep writes matching parity.
  - Extra input parity_inj (1 bit): on an accepted write, stored parity of the enabled bytes is inverted.
  - Extra output rsp_err (1 bit): valid with rsp_valid; 1 if any byte of the read word has a parity mismatch; reset value 0.
- When undefined: no parity storage, no parity_inj or rsp_err ports; behaviour otherwise identical.

Decomposition:
- Package memory_hs_pkg:
  - state_e enum {CLEAR, READY}.
  - Localparam BYTES = DATA_WIDTH/8.
  - Function for byte-merge under enables.
  - Function for per-byte parity.
- One sub-module, memory_hs_rd_pipe: RD_LATENCY-1 stage valid/data shift pipeline with synchronous flush; carries the rsp_err bit when parity is enabled.

Test Plan:
- Release reset, idle -> busy=1, req_ready=0 for exactly 2**ADDR_WIDTH cycles. Then READY; read of addr 0x0000 and 0xFFFF returns 0xFFFFFFFF.
- Write addr 0x0010 data 0xAABBCCDD be=0b0101, then read -> 0xFFBBFFDD after RD_LATENCY cycles. Repeat for RD_LATENCY=1 and 4.
- Write 0x12345678 to addr 5, next cycle read addr 5 -> 0x12345678.
- Single request rd=1 wr=1 addr 5 data 0x0 be=0xF -> response 0x12345678; a following read returns 0x00000000.
- Stream 8 back-to-back reads of addr 0..7 after distinct writes -> 8 consecutive rsp_valid cycles in order. Assert reset mid-stream -> no further rsp_valid, and busy=1 next cycle.
- With MEMORY_HS_PARITY_EN: write addr 3 with parity_inj=1 be=0x1, then read -> rsp_err=1. Rewrite without injection, then read -> rsp_err=0.
